// File: rtl/btn_condition.sv
// Push-button / mode-switch conditioner: 2-FF sync, tick-sampled debounce, edge pulses, one-hot key.
// Optional ready->start interlock FSM is compiled in with BTN_SEQ_LOCK_EN.
module btn_db_lane #(
  parameter int DB_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DB_TICKS + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Any tick that agrees with the stable level restarts the run, so only
  // DB_TICKS consecutive disagreeing ticks move the level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (tick) begin
        if (sync[1] != level) begin
          if (cnt == CW'(DB_TICKS - 1)) begin
            level <= sync[1];
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end
endmodule

module btn_condition #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1_000,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ready,
  input  logic       btn_start,
  input  logic [3:0] sw_key,
  output logic       ready,
  output logic       start,
  output logic [3:0] key,
  output logic       tick_1k
);
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int DW        = $clog2(DIV);
  localparam int NUM_LANES = 6;

  logic [DW-1:0]          div_cnt;
  logic [NUM_LANES-1:0]   raw, lvl;
  logic [1:0]             lvl_d;
  logic                   ready_p, start_p;
  logic [3:0]             kv;
  logic                   key_onehot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           div_cnt <= '0;
    else if (div_cnt == DW'(DIV - 1))   div_cnt <= '0;
    else                                div_cnt <= div_cnt + 1'b1;
  end

  assign tick_1k = (div_cnt == DW'(DIV - 1));

  // lane 0 = ready, lane 1 = start, lanes 2..5 = switches
  assign raw = {sw_key, btn_start, btn_ready};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    btn_db_lane #(.DB_TICKS(DB_TICKS)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_1k),
      .raw   (raw[i]),
      .level (lvl[i])
    );
  end

  assign kv         = lvl[5:2];
  assign key_onehot = (kv != 4'd0) && ((kv & (kv - 4'd1)) == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_d   <= '0;
      ready_p <= 1'b0;
      start_p <= 1'b0;
      key     <= 4'b0001;
    end else begin
      lvl_d   <= lvl[1:0];
      ready_p <= lvl[0] & ~lvl_d[0];
      start_p <= lvl[1] & ~lvl_d[1];
      if (key_onehot) key <= kv;
    end
  end

`ifdef BTN_SEQ_LOCK_EN
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // A ready in the same cycle as a start keeps the sequence armed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ready_p) state_nx = ARMED;
      ARMED:   if (start_p && !ready_p) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = ready_p;
    start = start_p && (state == ARMED);
  end
`else
  assign ready = ready_p;
  assign start = start_p;
`endif
endmodule

// File: tb/tb_btn_condition.sv
// Directed self-checking bench for btn_condition at DIV=10, DB_TICKS=3.
module tb_btn_condition;
`ifdef BTN_SEQ_LOCK_EN
  localparam int LOCK = 1;
`else
  localparam int LOCK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ready = 1'b0;
  logic       btn_start = 1'b0;
  logic [3:0] sw_key = 4'b0001;
  logic       ready, start, tick_1k;
  logic [3:0] key;

  int checks = 0;
  int failures = 0;
  int nr, ns, nb;

  btn_condition #(.CLK_HZ(100), .TICK_HZ(10), .DB_TICKS(3)) dut (
    .clk(clk), .rst(rst), .btn_ready(btn_ready), .btn_start(btn_start),
    .sw_key(sw_key), .ready(ready), .start(start), .key(key), .tick_1k(tick_1k)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count high samples of ready/start (and coincident ones) over n clocks.
  task automatic watch(input int n, output int r, output int s, output int b);
    r = 0; s = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      r += int'(ready);
      s += int'(start);
      b += int'(ready & start);
    end
  endtask

  task automatic wait_tick(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (tick_1k) got = 1'b1;
    end
    chk(tag, int'(got), 1);
  endtask

  initial begin
    // 1: reset values and divider phase
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_tick", int'(tick_1k), 0);
    chk("rst_key", int'(key), 1);
    rst = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("tick_%0d", i), int'(tick_1k), (i % 10 == 9) ? 1 : 0);
    end

    // 2: clean ready press and release
    btn_ready = 1'b1;
    watch(43, nr, ns, nb);
    chk("ready_press", nr, 1);
    chk("ready_press_nostart", ns, 0);
    watch(30, nr, ns, nb);
    chk("ready_hold_quiet", nr, 0);
    btn_ready = 1'b0;
    watch(60, nr, ns, nb);
    chk("ready_release", nr, 0);

    // 3: bouncy start, then stable
    for (int k = 0; k < 5; k++) begin
      btn_start = 1'b1;
      watch(10, nr, ns, nb);
      chk($sformatf("bounce_hi_%0d", k), ns, 0);
      btn_start = 1'b0;
      watch(10, nr, ns, nb);
      chk($sformatf("bounce_lo_%0d", k), ns, 0);
    end
    btn_start = 1'b1;
    watch(43, nr, ns, nb);
    chk("start_settled", ns, 1);
    btn_start = 1'b0;
    watch(60, nr, ns, nb);
    chk("start_release", ns, 0);

    // 4: key validation
    chk("key_init", int'(key), 1);
    sw_key = 4'b0100;
    watch(5, nr, ns, nb);
    chk("key_not_yet", int'(key), 1);
    watch(50, nr, ns, nb);
    chk("key_0100", int'(key), 4);
    sw_key = 4'b0110;
    watch(50, nr, ns, nb);
    chk("key_multihot", int'(key), 4);
    sw_key = 4'b0000;
    watch(50, nr, ns, nb);
    chk("key_zero", int'(key), 4);

    // 5: reset during a 2-tick-old press
    wait_tick("tick_wait");
    btn_ready = 1'b1;
    watch(25, nr, ns, nb);
    chk("mid_press_nopulse", nr, 0);
    rst = 1'b0;
    #3;
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_tick", int'(tick_1k), 0);
    chk("mid_rst_key", int'(key), 1);
    @(negedge clk);
    rst = 1'b1;
    watch(43, nr, ns, nb);
    chk("post_rst_pulse", nr, 1);
    watch(20, nr, ns, nb);
    chk("post_rst_quiet", nr, 0);
    btn_ready = 1'b0;
    watch(60, nr, ns, nb);
    chk("post_rst_release", nr, 0);

    // 6: ready/start sequencing
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    btn_start = 1'b1;
    watch(50, nr, ns, nb);
    chk("seq_start_first", ns, LOCK ? 0 : 1);
    btn_start = 1'b0;
    watch(50, nr, ns, nb);
    btn_ready = 1'b1;
    watch(50, nr, ns, nb);
    chk("seq_ready", nr, 1);
    btn_ready = 1'b0;
    watch(50, nr, ns, nb);
    btn_start = 1'b1;
    watch(50, nr, ns, nb);
    chk("seq_start_armed", ns, 1);
    btn_start = 1'b0;
    watch(50, nr, ns, nb);
    chk("seq_quiet", nr + ns, 0);
    btn_ready = 1'b1;
    btn_start = 1'b1;
    watch(50, nr, ns, nb);
    chk("both_ready", nr, 1);
    chk("both_start", ns, LOCK ? 0 : 1);
    chk("both_same_cycle", nb, LOCK ? 0 : 1);
    btn_ready = 1'b0;
    btn_start = 1'b0;
    watch(50, nr, ns, nb);
    chk("both_release", nr + ns, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
